// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the switch debouncer (sw_debounce, debounce_bit).
// Covers both builds, with and without SW_DEBOUNCE_EVCNT_EN.
package sw_debounce_pkg;

  typedef enum logic {
    StStable,
    StCounting
  } bit_state_e;

  localparam int unsigned DefaultWidth = 9;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser, stability counter and two-state FSM.
// It produces the accepted level, registered edge pulses and a counting flag.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept,
  output logic counting
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bit_state_e       state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      state_q  <= StStable;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      StStable: begin
        if (sync2_q != stable_q) begin
          state_d = StCounting;
          cnt_d   = CNT_W'(1);
        end
      end
      StCounting: begin
        if (sync2_q == stable_q) begin
          // Reverted before acceptance: discard the partial count.
          state_d = StStable;
        end else if (cnt_q == LastCnt) begin
          state_d  = StStable;
          stable_d = sync2_q;
          rise_d   = sync2_q;
          fall_d   = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign stable   = stable_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign accept   = rise_d | fall_d;
  assign counting = (state_q == StCounting);

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer top: WIDTH independent debounce_bit lanes plus global change/busy flags.
// Define SW_DEBOUNCE_EVCNT_EN to add the 8-bit wrapping change-event counter output evcnt.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = DefaultWidth,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             busy
`ifdef SW_DEBOUNCE_EVCNT_EN
  ,
  output logic [7:0]       evcnt
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] counting;
  logic             changed_q;
  logic             changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .raw     (sw_i[i]),
      .stable  (sw_o[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .accept  (accept[i]),
      .counting(counting[i])
    );
  end

  // One pulse no matter how many lanes accept on the same edge.
  assign changed_d = |accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
  assign busy    = |counting;

`ifdef SW_DEBOUNCE_EVCNT_EN
  logic [7:0] evcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evcnt_q <= 8'd0;
    end else if (changed_d) begin
      evcnt_q <= evcnt_q + 8'd1;
    end
  end

  assign evcnt = evcnt_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, WIDTH=9.
// The evcnt wrap check is built only when SW_DEBOUNCE_EVCNT_EN is defined.
module tb_sw_debounce;

  localparam int unsigned W  = 9;
  localparam int unsigned DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_i = '0;
  logic [W-1:0] sw_o, rise, fall;
  logic         changed, busy;
`ifdef SW_DEBOUNCE_EVCNT_EN
  logic [7:0]   evcnt;
`endif

  int tests  = 0;
  int failed = 0;

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_i   (sw_i),
    .sw_o   (sw_o),
    .rise   (rise),
    .fall   (fall),
    .changed(changed),
    .busy   (busy)
`ifdef SW_DEBOUNCE_EVCNT_EN
    ,
    .evcnt  (evcnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_sw_o", 16'(sw_o), 16'h000);
    check("rst_busy", 16'(busy), 16'h0);
    step(2);
    rst = 1'b0;

    // Idle with all switches low
    step(10);
    check("idle_sw_o", 16'(sw_o), 16'h000);
    check("idle_rise", 16'(rise), 16'h000);
    check("idle_fall", 16'(fall), 16'h000);
    check("idle_changed", 16'(changed), 16'h0);
    check("idle_busy", 16'(busy), 16'h0);

    // Single bit rise: sampled at edge 1, accepted at edge 6
    sw_i = 9'h008;
    step(2);
    check("b3_e2_busy", 16'(busy), 16'h0);
    step(1);
    check("b3_e3_busy", 16'(busy), 16'h1);
    check("b3_e3_sw_o", 16'(sw_o), 16'h000);
    step(2);
    check("b3_e5_busy", 16'(busy), 16'h1);
    check("b3_e5_sw_o", 16'(sw_o), 16'h000);
    check("b3_e5_rise", 16'(rise), 16'h000);
    step(1);
    check("b3_e6_sw_o", 16'(sw_o), 16'h008);
    check("b3_e6_rise", 16'(rise), 16'h008);
    check("b3_e6_changed", 16'(changed), 16'h1);
    check("b3_e6_busy", 16'(busy), 16'h0);
    step(1);
    check("b3_e7_rise", 16'(rise), 16'h000);
    check("b3_e7_changed", 16'(changed), 16'h0);
    check("b3_e7_sw_o", 16'(sw_o), 16'h008);

    // Glitch on bit 5 held for three samples: counted to 3 then abandoned
    step(2);
    sw_i = 9'h028;
    step(3);
    sw_i = 9'h008;
    step(2);
    check("gl_e5_busy", 16'(busy), 16'h1);
    step(1);
    check("gl_e6_busy", 16'(busy), 16'h0);
    check("gl_e6_sw_o", 16'(sw_o), 16'h008);
    check("gl_e6_changed", 16'(changed), 16'h0);
    check("gl_e6_rise", 16'(rise), 16'h000);
    step(2);
    check("gl_e8_sw_o", 16'(sw_o), 16'h008);
    check("gl_e8_changed", 16'(changed), 16'h0);

    // Fall of bit 3
    sw_i = 9'h000;
    step(5);
    check("f3_e5_sw_o", 16'(sw_o), 16'h008);
    step(1);
    check("f3_e6_sw_o", 16'(sw_o), 16'h000);
    check("f3_e6_fall", 16'(fall), 16'h008);
    check("f3_e6_rise", 16'(rise), 16'h000);
    check("f3_e6_changed", 16'(changed), 16'h1);
    step(3);

    // Multi-bit simultaneous acceptance
    sw_i = 9'h181;
    step(5);
    check("mb_e5_sw_o", 16'(sw_o), 16'h000);
    check("mb_e5_busy", 16'(busy), 16'h1);
    step(1);
    check("mb_e6_sw_o", 16'(sw_o), 16'h181);
    check("mb_e6_rise", 16'(rise), 16'h181);
    check("mb_e6_changed", 16'(changed), 16'h1);
    step(1);
    check("mb_e7_changed", 16'(changed), 16'h0);
    check("mb_e7_rise", 16'(rise), 16'h000);

    // Reset mid-count with enable bit already accepted
    sw_i = 9'h100;
    step(6);
    check("rm_pre_sw_o", 16'(sw_o), 16'h100);
    check("rm_pre_fall", 16'(fall), 16'h081);
    step(2);
    sw_i = 9'h101;
    step(4);
    check("rm_counting_busy", 16'(busy), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rm_async_sw_o", 16'(sw_o), 16'h000);
    check("rm_async_busy", 16'(busy), 16'h0);
    step(1);
    rst = 1'b0;
    step(5);
    check("rm_e5_sw_o", 16'(sw_o), 16'h000);
    step(1);
    check("rm_e6_sw_o", 16'(sw_o), 16'h101);
    check("rm_e6_rise", 16'(rise), 16'h101);
    check("rm_e6_changed", 16'(changed), 16'h1);

`ifdef SW_DEBOUNCE_EVCNT_EN
    // 257 accepted toggles of bit 0 wrap the event counter to 1
    sw_i = 9'h000;
    rst  = 1'b1;
    step(1);
    rst = 1'b0;
    check("ev_rst", 16'(evcnt), 16'h00);
    for (int k = 0; k < 257; k++) begin
      sw_i[0] = ~sw_i[0];
      step(8);
    end
    check("ev_wrap", 16'(evcnt), 16'h01);
    check("ev_sw_o", 16'(sw_o), 16'h001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
